// File: rtl/pio_uart_pkg.sv
// Shared types for the PIO-to-UART transmitter: FSM state encoding and frame sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pio_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // Number of bit periods in one frame (start + data + optional parity + stop).
    function automatic int frame_bits(input int data_w, input int parity_en, input int stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

    // Bit periods per frame for the default 7-bit, parity-on, 1-stop-bit build.
    localparam int FRAME_BITS_DFLT = frame_bits(7, 1, 1);

endpackage

// File: rtl/pio_uart_tx_if.sv
// Bundle between the PIO out_port side and the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: none; the PIO value is level-sampled, status flows back as levels/pulses.
// Signals: in_port (PIO value), tx (serial line), busy, done (pulse), dropped (pulse).
interface pio_uart_tx_if #(
    parameter int DATA_W = 7
);
    logic [DATA_W-1:0] in_port;
    logic              tx;
    logic              busy;
    logic              done;
    logic              dropped;

    modport master (output in_port, input tx, busy, done, dropped);
    modport slave  (input in_port, output tx, busy, done, dropped);
endinterface

// File: rtl/pio_uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: tick_o is combinational from the count register.
// Backpressure: none; clr_i holds the count at zero.
// Ports: clk, reset_n, clr_i (hold count at 0), tick_o (last cycle of a bit period).
module pio_uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pio_uart_tx.sv
// Watches the PIO out_port value and sends every new value as one async UART frame.
// Latency: in_port change at edge N -> start bit on tx from edge N+2.
// Backpressure: none; changes during a frame are held pending, superseded values are dropped.
// Ports: clk, reset_n (async, active-low), pio (slave: in_port in; tx, busy, done, dropped out).
module pio_uart_tx
    import pio_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 7,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input logic          clk,
    input logic          reset_n,
    pio_uart_tx_if.slave pio
);
    localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_INV   = (PARITY_ODD != 0);
    localparam logic             PAR_ON    = (PARITY_EN != 0);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] in_q, in_prev_q;
    logic [DATA_W-1:0] last_sent_q, last_sent_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              pending_q, pending_d;
    logic              tick;
    logic              busy;
    logic              tx_bit;
    logic              done_pulse;

    // The counter is held clear in IDLE and wraps on its own tick, which is exactly
    // when every non-IDLE state hands over, so each state starts at count 0.
    pio_uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    assign busy      = (state_q != IDLE);
    assign pending_d = busy && (in_q != last_sent_q);

    always_comb begin
        state_d     = state_q;
        last_sent_d = last_sent_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        tx_bit      = 1'b1;
        done_pulse  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_q != last_sent_q) begin
                    shreg_d     = in_q;
                    last_sent_d = in_q;
                    state_d     = START;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx_bit = shreg_q[0];
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = PAR_ON ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                // last_sent_q holds the frame's data for its whole duration.
                tx_bit = (^last_sent_q) ^ PAR_INV;
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        done_pulse = 1'b1;
                        bit_idx_d  = '0;
                        state_d    = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_q        <= '0;
            in_prev_q   <= '0;
            last_sent_q <= '0;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_q        <= pio.in_port;
            in_prev_q   <= in_q;
            last_sent_q <= last_sent_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            pending_q   <= pending_d;
        end
    end

    // A pending value is lost only when another unsent value replaces it; moving
    // back to the value already on the wire cancels the pending send instead.
    assign pio.dropped = pending_q && pending_d && (in_q != in_prev_q);
    assign pio.tx      = tx_bit;
    assign pio.busy    = busy;
    assign pio.done    = done_pulse;
endmodule

// File: tb/tb_pio_uart_tx.sv
module tb_pio_uart_tx;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pio_uart_tx_if #(.DATA_W(7)) if_e ();
    pio_uart_tx_if #(.DATA_W(7)) if_o ();

    pio_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut_e (.clk(clk), .reset_n(reset_n), .pio(if_e));
    pio_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        dut_o (.clk(clk), .reset_n(reset_n), .pio(if_o));

    always #5 clk = ~clk;

    logic tx_e_s [41];
    logic tx_o_s [41];
    int   busy_cnt, done_cnt, done_t, drop_cnt;
    logic busy_end;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [6:0] v);
        reset_n = 1'b0;
        if_e.in_port = v;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Steps until the even-parity DUT drives a start bit; n = steps taken, -1 if none.
    task automatic wait_start(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (if_e.tx === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    // Records 41 samples starting at the first start-bit sample (t=0); optional
    // in_port changes are applied right after sampling at t1 / t2.
    task automatic capture(input int t1, input logic [6:0] v1, input int t2, input logic [6:0] v2);
        busy_cnt = 0; done_cnt = 0; done_t = -1; drop_cnt = 0;
        for (int t = 0; t <= 40; t++) begin
            tx_e_s[t] = if_e.tx;
            tx_o_s[t] = if_o.tx;
            if (if_e.busy === 1'b1) busy_cnt++;
            if (if_e.done === 1'b1) begin done_cnt++; done_t = t; end
            if (if_e.dropped === 1'b1) drop_cnt++;
            if (t == t1) if_e.in_port = v1;
            if (t == t2) if_e.in_port = v2;
            if (t < 40) step();
        end
        busy_end = if_e.busy;
    endtask

    task automatic check_frame(input string tag, input logic [6:0] data, input logic par);
        logic exp_bit;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) exp_bit = 1'b0;
            else if (k <= 7) exp_bit = data[k-1];
            else if (k == 8) exp_bit = par;
            else exp_bit = 1'b1;
            check($sformatf("%s_bit%0d", tag, k), 32'(tx_e_s[4*k+2]), 32'(exp_bit));
        end
        check({tag, "_busy_cycles"}, busy_cnt, 40);
        check({tag, "_busy_end"}, 32'(busy_end), 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_t, 39);
    endtask

    initial begin
        int n;
        int tx_low, busy_hi, done_hi;
        logic [6:0] exp_odd;

        // Reset state
        if_e.in_port = 7'h00;
        if_o.in_port = 7'h00;
        reset_n = 1'b0;
        step();
        step();
        check("rst_tx", 32'(if_e.tx), 1);
        check("rst_busy", 32'(if_e.busy), 0);
        check("rst_done", 32'(if_e.done), 0);
        check("rst_dropped", 32'(if_e.dropped), 0);
        reset_n = 1'b1;

        // 1: idle with value 0 for 100 cycles
        tx_low = 0; busy_hi = 0; done_hi = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (if_e.tx !== 1'b1) tx_low++;
            if (if_e.busy !== 1'b0) busy_hi++;
            if (if_e.done !== 1'b0) done_hi++;
        end
        check("idle_tx_low", tx_low, 0);
        check("idle_busy", busy_hi, 0);
        check("idle_done", done_hi, 0);

        // 2/3: 7'h41 on both even and odd builds
        if_e.in_port = 7'h41;
        if_o.in_port = 7'h41;
        step();
        check("t2_lat_tx_still_idle", 32'(if_e.tx), 1);
        wait_start(5, n);
        check("t2_lat_start", n, 1);
        check("t2_busy_at_start", 32'(if_e.busy), 1);
        capture(-1, 7'h00, -1, 7'h00);
        check_frame("t2", 7'h41, 1'b0);
        check("t2_dropped", drop_cnt, 0);
        exp_odd = 7'h41;
        check("t3_start", 32'(tx_o_s[2]), 0);
        for (int k = 1; k <= 7; k++)
            check($sformatf("t3_bit%0d", k), 32'(tx_o_s[4*k+2]), 32'(exp_odd[k-1]));
        check("t3_parity", 32'(tx_o_s[34]), 1);
        check("t3_stop", 32'(tx_o_s[38]), 1);

        // 4: two changes during a frame -> one drop, then only the latest is sent
        do_reset(7'h00);
        if_e.in_port = 7'h41;
        wait_start(4, n);
        check("t4_lat_start", n, 2);
        capture(5, 7'h42, 10, 7'h43);
        check_frame("t4a", 7'h41, 1'b0);
        check("t4a_dropped", drop_cnt, 1);
        wait_start(3, n);
        check("t4_gap", n, 1);
        capture(-1, 7'h00, -1, 7'h00);
        check_frame("t4b", 7'h43, 1'b1);
        check("t4b_dropped", drop_cnt, 0);
        wait_start(20, n);
        check("t4_no_more_frames", n, -1);

        // 5: change then return to the in-flight value -> no second frame
        if_e.in_port = 7'h41;
        wait_start(4, n);
        check("t5_lat_start", n, 2);
        capture(5, 7'h42, 20, 7'h41);
        check_frame("t5", 7'h41, 1'b0);
        check("t5_dropped", drop_cnt, 0);
        wait_start(20, n);
        check("t5_no_second_frame", n, -1);

        // 6: reset mid-frame
        do_reset(7'h00);
        if_e.in_port = 7'h41;
        wait_start(4, n);
        check("t6_lat_start", n, 2);
        for (int i = 0; i < 15; i++) step();
        check("t6_busy_before_rst", 32'(if_e.busy), 1);
        reset_n = 1'b0;
        #1;
        check("t6_async_tx", 32'(if_e.tx), 1);
        check("t6_async_busy", 32'(if_e.busy), 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("t6_rel_tx_idle", 32'(if_e.tx), 1);
        step();
        check("t6_rel_start_tx", 32'(if_e.tx), 0);
        check("t6_rel_start_busy", 32'(if_e.busy), 1);
        capture(-1, 7'h00, -1, 7'h00);
        check_frame("t6", 7'h41, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
